// File: rtl/dwt_tile_ctrl_if.sv
// Valid/ready word stream used for the controller's coefficient/data input and its result output.
interface dwt_tile_ctrl_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dwt_tile_ctrl.sv
// Job/tile sequencer for the 6x6 DWT PE array: loads the transform once per job, then per tile
// loads data, waits out the PE latency, captures the array result and streams it row-major.
module dwt_tile_ctrl #(
  parameter int X_DIM      = 6,
  parameter int Y_DIM      = 6,
  parameter int DATA_WIDTH = 16,
  parameter int PE_LATENCY = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [15:0]                                  num_tiles,
  output logic                                         busy,
  output logic                                         done,
  dwt_tile_ctrl_if.slave                               in_s,
  output logic [X_DIM-1:0][Y_DIM-1:0][DATA_WIDTH-1:0]  coef_mat,
  output logic [X_DIM-1:0][Y_DIM-1:0][DATA_WIDTH-1:0]  data_mat,
  output logic                                         pe_rst,
  input  logic [X_DIM-1:0][Y_DIM-1:0][DATA_WIDTH-1:0]  comp_in,
  dwt_tile_ctrl_if.master                              out_m
);

  localparam int unsigned NUM_EL = X_DIM * Y_DIM;
  localparam int          LAT_W  = (PE_LATENCY < 1) ? 1 : $clog2(PE_LATENCY + 1);

  localparam logic [5:0]       IDX_LAST = 6'(NUM_EL - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PE_LATENCY - 1);

  // Matrices are stored flat so the row-major element index addresses them directly;
  // the flat and [row][col] packed views have identical bit layouts.
  typedef logic [NUM_EL-1:0][DATA_WIDTH-1:0] flat_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_COEF,
    S_LOAD_DATA,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q,  state_d;
  logic [5:0]       idx_q,    idx_d;
  logic [LAT_W-1:0] lat_q,    lat_d;
  logic [15:0]      tile_q,   tile_d;
  logic [15:0]      ntiles_q, ntiles_d;
  flat_t            coef_q,   coef_d;
  flat_t            data_q,   data_d;
  flat_t            buf_q,    buf_d;

  logic             last_el;
  logic [15:0]      tile_inc;

  assign last_el  = (idx_q == IDX_LAST);
  assign tile_inc = tile_q + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      lat_q    <= '0;
      tile_q   <= '0;
      ntiles_q <= '0;
      coef_q   <= '0;
      data_q   <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lat_q    <= lat_d;
      tile_q   <= tile_d;
      ntiles_q <= ntiles_d;
      coef_q   <= coef_d;
      data_q   <= data_d;
      buf_q    <= buf_d;
    end
  end

  // Handshake outputs decode from state only, so neither valid nor ready loops combinationally.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lat_d       = lat_q;
    tile_d      = tile_q;
    ntiles_d    = ntiles_q;
    coef_d      = coef_q;
    data_d      = data_q;
    buf_d       = buf_q;
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    in_s.ready  = 1'b0;
    out_m.valid = 1'b0;
    pe_rst      = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ntiles_d = num_tiles;
          tile_d   = '0;
          idx_d    = '0;
          state_d  = (num_tiles == 16'd0) ? S_DONE : S_LOAD_COEF;
        end
      end

      S_LOAD_COEF: begin
        in_s.ready = 1'b1;
        if (in_s.valid) begin
          coef_d[idx_q] = in_s.data;
          if (last_el) begin
            idx_d   = '0;
            state_d = S_LOAD_DATA;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end

      S_LOAD_DATA: begin
        in_s.ready = 1'b1;
        if (in_s.valid) begin
          data_d[idx_q] = in_s.data;
          if (last_el) begin
            idx_d   = '0;
            lat_d   = '0;
            state_d = S_COMPUTE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end

      S_COMPUTE: begin
        pe_rst = 1'b0;
        lat_d  = lat_q + 1'b1;
        if (lat_q == LAT_LAST) begin
          buf_d   = comp_in;
          idx_d   = '0;
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        out_m.valid = 1'b1;
        if (out_m.ready) begin
          if (last_el) begin
            idx_d   = '0;
            tile_d  = tile_inc;
            state_d = (tile_inc == ntiles_q) ? S_DONE : S_LOAD_DATA;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign coef_mat   = coef_q;
  assign data_mat   = data_q;
  assign out_m.data = buf_q[idx_q];

endmodule

// File: tb/tb_dwt_tile_ctrl.sv
// Directed bench for dwt_tile_ctrl with a behavioural PE-array model and a result scoreboard.
module tb_dwt_tile_ctrl;
  localparam int DW     = 16;
  localparam int XD     = 6;
  localparam int YD     = 6;
  localparam int NUM    = XD * YD;
  localparam int PE_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_tiles;
  logic        busy, done, pe_rst;
  logic [XD-1:0][YD-1:0][DW-1:0] coef_mat, data_mat, comp_in;

  dwt_tile_ctrl_if #(.DATA_WIDTH(DW)) in_if ();
  dwt_tile_ctrl_if #(.DATA_WIDTH(DW)) out_if ();

  dwt_tile_ctrl #(
    .X_DIM(XD), .Y_DIM(YD), .DATA_WIDTH(DW), .PE_LATENCY(PE_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
    .busy(busy), .done(done), .in_s(in_if),
    .coef_mat(coef_mat), .data_mat(data_mat), .pe_rst(pe_rst),
    .comp_in(comp_in), .out_m(out_if)
  );

  always #5 clk = ~clk;

  // PE array model: the product is only presented in the cycle the array would deliver it;
  // any other cycle shows a corrupted value.
  int pe_cyc;
  logic [DW-1:0] acc_m;
  always_ff @(posedge clk) begin
    if (pe_rst) pe_cyc <= 0;
    else        pe_cyc <= pe_cyc + 1;
  end
  always_comb begin
    acc_m   = '0;
    comp_in = '0;
    for (int r = 0; r < XD; r++)
      for (int c = 0; c < YD; c++) begin
        acc_m = '0;
        for (int k = 0; k < XD; k++) acc_m = acc_m + coef_mat[r][k] * data_mat[k][c];
        comp_in[r][c] = (pe_cyc == PE_LAT - 1) ? acc_m : ~acc_m;
      end
  end

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] cf [NUM];
  logic [DW-1:0] dt [NUM];
  logic [DW-1:0] in_q [$];
  logic [DW-1:0] sb_q [$];

  int n_out, n_done, n_busy, n_inrdy, n_runs, lat_bad, pe_bad, stall_bad;
  int done_cyc, last_out_cyc, low_run;
  bit finished, prev_stall;
  logic [DW-1:0] prev_data, exp_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] gold(input int r, input int c);
    logic [DW-1:0] a;
    a = '0;
    for (int k = 0; k < XD; k++) a = a + cf[r*YD+k] * dt[k*YD+c];
    return a;
  endfunction

  task automatic load_coef();
    for (int i = 0; i < NUM; i++) in_q.push_back(cf[i]);
  endtask

  task automatic push_tile();
    for (int i = 0; i < NUM; i++) in_q.push_back(dt[i]);
    for (int r = 0; r < XD; r++)
      for (int c = 0; c < YD; c++) sb_q.push_back(gold(r, c));
  endtask

  task automatic set_identity();
    for (int i = 0; i < NUM; i++) begin
      cf[i] = (i / YD == i % YD) ? 16'd1 : 16'd0;
      dt[i] = DW'(i);
    end
  endtask

  task automatic rand_coef();
    for (int i = 0; i < NUM; i++) cf[i] = DW'($urandom);
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM; i++) dt[i] = DW'($urandom);
  endtask

  // Called at a negedge in DRAIN; reset lands mid-cycle, away from any clock edge.
  task automatic do_abort();
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_if.valid), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_pe_rst",    32'(pe_rst), 1);
    chk("rst_in_ready",  32'(in_if.ready), 0);
    chk("rst_done",      32'(done), 0);
    chk("rst_out_data",  32'(out_if.data), 0);
    chk("rst_mats",      32'(coef_mat == '0 && data_mat == '0), 1);
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("rst_no_done", n_done, 0);
    rst = 1'b1;
    in_q.delete();
    sb_q.delete();
  endtask

  task automatic run_job(input logic [15:0] nt, input int budget, input bit rnd_in,
                         input bit slow_rdy, input int glitch_cyc, input int abort_at);
    n_out = 0; n_done = 0; n_busy = 0; n_inrdy = 0; n_runs = 0;
    lat_bad = 0; pe_bad = 0; stall_bad = 0; done_cyc = -1; last_out_cyc = -1;
    low_run = 0; finished = 1'b0; prev_stall = 1'b0; prev_data = '0;
    start = 1'b1;
    num_tiles = nt;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (busy) n_busy++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (in_if.ready) n_inrdy++;
      if (!pe_rst) begin
        low_run++;
        if (in_if.ready || out_if.valid || !busy) pe_bad++;
      end else if (low_run != 0) begin
        if (low_run != PE_LAT) lat_bad++;
        n_runs++;
        low_run = 0;
      end
      if (prev_stall && out_if.valid && out_if.data !== prev_data) stall_bad++;
      if (n_done > 0 && !busy) begin finished = 1'b1; break; end
      if (cyc > 0) start = 1'b0;
      if (cyc == glitch_cyc) begin start = 1'b1; num_tiles = nt + 16'd5; end
      in_if.valid  = (in_q.size() > 0) && (!rnd_in || $urandom_range(0, 1) == 1);
      in_if.data   = in_if.valid ? in_q[0] : DW'($urandom);
      out_if.ready = !slow_rdy || (cyc % 3 == 0);
      if (in_if.valid && in_if.ready) void'(in_q.pop_front());
      if (out_if.valid && out_if.ready) begin
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          exp_w = sb_q.pop_front();
          chk("out_data", 32'(out_if.data), 32'(exp_w));
        end
        n_out++;
        last_out_cyc = cyc;
        if (n_out == abort_at) begin do_abort(); finished = 1'b1; break; end
      end
      prev_stall = out_if.valid && !out_if.ready;
      prev_data  = out_if.data;
      @(negedge clk);
    end
    start = 1'b0;
    in_if.valid = 1'b0;
    out_if.ready = 1'b0;
    chk("job_finished", 32'(finished), 1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; num_tiles = '0;
    in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b0;
    #1;
    chk("reset_busy",      32'(busy), 0);
    chk("reset_done",      32'(done), 0);
    chk("reset_in_ready",  32'(in_if.ready), 0);
    chk("reset_out_valid", 32'(out_if.valid), 0);
    chk("reset_pe_rst",    32'(pe_rst), 1);
    chk("reset_out_data",  32'(out_if.data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // identity transform, one tile
    set_identity();
    load_coef();
    push_tile();
    run_job(16'd1, 1000, 1'b0, 1'b0, -1, -1);
    chk("id_outputs",    n_out, NUM);
    chk("id_done_pulse", n_done, 1);
    chk("id_busy",       n_busy, 36 + 36 + PE_LAT + 36 + 1);
    chk("id_done_after", done_cyc, last_out_cyc + 1);
    chk("id_in_ready",   n_inrdy, 72);
    chk("id_lat_runs",   n_runs, 1);
    chk("id_lat_len",    lat_bad, 0);
    chk("id_pe_window",  pe_bad, 0);

    // zero-tile job
    run_job(16'd0, 20, 1'b0, 1'b0, -1, -1);
    chk("zero_done",     n_done, 1);
    chk("zero_busy",     n_busy, 1);
    chk("zero_in_ready", n_inrdy, 0);
    chk("zero_outputs",  n_out, 0);

    // three tiles, random input gaps, out_ready one cycle in three
    rand_coef();
    load_coef();
    for (int t = 0; t < 3; t++) begin rand_data(); push_tile(); end
    run_job(16'd3, 6000, 1'b1, 1'b1, -1, -1);
    chk("bp_outputs",    n_out, 108);
    chk("bp_done_pulse", n_done, 1);
    chk("bp_done_after", done_cyc, last_out_cyc + 1);
    chk("bp_stall_hold", stall_bad, 0);
    chk("bp_lat_runs",   n_runs, 3);
    chk("bp_lat_len",    lat_bad, 0);
    chk("bp_pe_window",  pe_bad, 0);
    chk("bp_sb_left",    sb_q.size(), 0);
    chk("bp_in_left",    in_q.size(), 0);

    // start and num_tiles disturbed while the job is running
    rand_coef();
    load_coef();
    for (int t = 0; t < 2; t++) begin rand_data(); push_tile(); end
    run_job(16'd2, 2000, 1'b0, 1'b0, 40, -1);
    chk("gl_outputs",    n_out, 72);
    chk("gl_done_pulse", n_done, 1);
    chk("gl_busy",       n_busy, 36 + 2 * (72 + PE_LAT) + 1);
    chk("gl_lat_runs",   n_runs, 2);
    chk("gl_sb_left",    sb_q.size(), 0);

    // reset during DRAIN, then a clean job afterwards
    rand_coef();
    load_coef();
    rand_data();
    push_tile();
    run_job(16'd1, 1000, 1'b0, 1'b0, -1, 10);
    chk("ab_outputs", n_out, 10);

    set_identity();
    load_coef();
    push_tile();
    run_job(16'd1, 1000, 1'b0, 1'b0, -1, -1);
    chk("rec_outputs",    n_out, NUM);
    chk("rec_done_pulse", n_done, 1);
    chk("rec_busy",       n_busy, 36 + 36 + PE_LAT + 36 + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
